fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-based request issue, in-order response queue, redirect squash.
// Define FETCH_BYPASS_EN to forward a response arriving into an empty queue straight to the consumer.
module fetch_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int PC_INC = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] instr_pc_inc,
    output logic              err
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam int UW = OW + 1;
    localparam int SW = OW + 2;
    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [OW-1:0]     count;
    logic [OW-1:0]     outst;
    logic [SW-1:0]     squash;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;

    logic [DATA_W-1:0] q_data [DEPTH];
    logic [ADDR_W-1:0] q_pc [DEPTH];

    logic          empty;
    logic          rsp_drop;
    logic          rsp_hit;
    logic          rsp_err;
    logic          byp;
    logic          pop;
    logic          pop_q;
    logic          push;
    logic          req_fire;
    logic [UW-1:0] used;

    assign empty = (count == '0);

    // A response belongs to the squashed group first, then to live requests.
    assign rsp_drop = imem_rsp_valid && (squash != '0);
    assign rsp_hit  = imem_rsp_valid && (squash == '0) && (outst != '0);
    assign rsp_err  = imem_rsp_valid && (squash == '0) && (outst == '0);

`ifdef FETCH_BYPASS_EN
    assign byp = rsp_hit && empty && !redirect;
`else
    assign byp = 1'b0;
`endif

    assign used = {1'b0, count} + {1'b0, outst};

    assign imem_req_valid = rst && !halt && !redirect && (used < UW'(DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign instr_valid  = rst && (!empty || byp);
    assign instr        = byp ? imem_rsp_data : q_data[head];
    assign instr_pc     = byp ? rsp_pc : q_pc[head];
    assign instr_pc_inc = instr_pc + INC;

    assign pop   = instr_valid && instr_ready && !redirect;
    assign pop_q = pop && !empty;
    assign push  = rsp_hit && !redirect && !(byp && instr_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc     <= RESET_PC;
            rsp_pc <= RESET_PC;
            count  <= '0;
            outst  <= '0;
            squash <= '0;
            head   <= '0;
            tail   <= '0;
            err    <= 1'b0;
        end else begin
            if (rsp_err) begin
                err <= 1'b1;
            end
            if (redirect) begin
                pc     <= redirect_pc;
                rsp_pc <= redirect_pc;
                count  <= '0;
                outst  <= '0;
                head   <= '0;
                tail   <= '0;
                // Everything still in flight, live or already squashed, gets dropped.
                squash <= squash + SW'(outst) - SW'(rsp_drop || rsp_hit);
            end else begin
                if (req_fire) begin
                    pc <= pc + INC;
                end
                if (rsp_hit) begin
                    rsp_pc <= rsp_pc + INC;
                end
                if (rsp_drop) begin
                    squash <= squash - SW'(1);
                end
                outst <= outst + OW'(req_fire) - OW'(rsp_hit);
                if (push) begin
                    tail <= tail + PW'(1);
                end
                if (pop_q) begin
                    head <= head + PW'(1);
                end
                count <= count + OW'(push) - OW'(pop_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_data[tail] <= imem_rsp_data;
            q_pc[tail]   <= rsp_pc;
        end
    end

endmodule
